// File: rtl/bcs_pkg.sv
// Shared definitions for the branch control stack: opcodes,
// redirect-unit state, interrupt level encoding and stack entry layout.
package bcs_pkg;

    localparam int BCS_AW = 16;
    localparam int BCS_LW = 3;

    localparam logic [5:0] OP_JMP  = 6'b011000;
    localparam logic [5:0] OP_CALL = 6'b011001;
    localparam logic [5:0] OP_RET  = 6'b010000;
    localparam logic [5:0] OP_RETI = 6'b010001;
    localparam logic [5:0] OP_JV   = 6'b011100;
    localparam logic [5:0] OP_JNV  = 6'b011101;
    localparam logic [5:0] OP_JZ   = 6'b011110;
    localparam logic [5:0] OP_JNZ  = 6'b011111;

    typedef enum logic {
        IDLE = 1'b0,
        ISR  = 1'b1
    } bcs_state_t;

    // All-ones sorts above every real irq index, so "idx < level"
    // reads naturally as "strictly higher priority".
    localparam logic [BCS_LW-1:0] LEVEL_NONE = '1;

    typedef struct packed {
        logic [1:0]        flags;
        logic [BCS_AW-1:0] addr;
        logic [BCS_LW-1:0] level;
    } bcs_entry_t;

endpackage

// File: rtl/bcs_ret_stack.sv
// Synchronous LIFO of return entries.
// Ports: push/pop/wdata in; top, full, empty, depth out.
module bcs_ret_stack
    import bcs_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  bcs_entry_t               wdata,
    output bcs_entry_t               top,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   depth
);

    localparam int PW = $clog2(DEPTH);

    bcs_entry_t     mem [DEPTH];
    logic [PW:0]    cnt;
    logic [PW-1:0]  top_idx;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign depth   = cnt;
    assign top_idx = cnt[PW-1:0] - 1'b1;
    assign top     = mem[top_idx];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[cnt[PW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + 1'b1;
        end else if (pop && !empty) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/branch_control_stack.sv
// PC redirect unit: jumps, CALL/RET/RETI, vectored prioritised irqs.
// In: op, current_address, jmp_address_pm, flag_ex, irq, irq_en.
// Out: pc_mux_sel/jmp_loc (comb), flag_restore(_vld), irq_ack,
// stack_depth, stack_ovf, stack_unf (registered).
// Define BCS_NESTED_IRQ_EN to let higher-priority irqs preempt an ISR.
// AW must match bcs_pkg::BCS_AW (stack entry layout).
module branch_control_stack
    import bcs_pkg::*;
#(
    parameter int             AW         = BCS_AW,
    parameter int             DEPTH      = 8,
    parameter int             NIRQ       = 4,
    parameter logic [AW-1:0]  VEC_BASE   = 'hF000,
    parameter int             VEC_STRIDE = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [5:0]               op,
    input  logic [AW-1:0]            current_address,
    input  logic [AW-1:0]            jmp_address_pm,
    input  logic [1:0]               flag_ex,
    input  logic [NIRQ-1:0]          irq,
    input  logic                     irq_en,
    output logic                     pc_mux_sel,
    output logic [AW-1:0]            jmp_loc,
    output logic [1:0]               flag_restore,
    output logic                     flag_restore_vld,
    output logic [NIRQ-1:0]          irq_ack,
    output logic [$clog2(DEPTH):0]   stack_depth,
    output logic                     stack_ovf,
    output logic                     stack_unf
);

    bcs_state_t         state;
    logic [BCS_LW-1:0]  level;
    logic [BCS_LW-1:0]  irq_idx;
    logic               irq_hit;
    logic               eligible;
    logic               accept;
    logic               is_call;
    logic               is_ret;
    logic               is_reti;
    logic               br_taken;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [AW-1:0]      vec_addr;
    bcs_entry_t         wdata;
    bcs_entry_t         top;

    bcs_ret_stack #(.DEPTH(DEPTH)) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .top   (top),
        .full  (full),
        .empty (empty),
        .depth (stack_depth)
    );

    assign is_call = (op == OP_CALL);
    assign is_reti = (op == OP_RETI);
    assign is_ret  = (op == OP_RET) || is_reti;

    // flag_ex[0] = V, flag_ex[1] = Z
    always_comb begin
        br_taken = 1'b0;
        unique case (op)
            OP_JMP:  br_taken = 1'b1;
            OP_JV:   br_taken = flag_ex[0];
            OP_JNV:  br_taken = !flag_ex[0];
            OP_JZ:   br_taken = flag_ex[1];
            OP_JNZ:  br_taken = !flag_ex[1];
            default: br_taken = 1'b0;
        endcase
    end

    // Lowest set bit wins.
    always_comb begin
        irq_hit = 1'b0;
        irq_idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (irq[i]) begin
                irq_hit = 1'b1;
                irq_idx = BCS_LW'(i);
            end
        end
    end

`ifdef BCS_NESTED_IRQ_EN
    assign eligible = (state == IDLE) || (irq_idx < level);
`else
    assign eligible = (state == IDLE);
`endif

    assign accept   = irq_en && irq_hit && !full && eligible;
    assign vec_addr = VEC_BASE + AW'(VEC_STRIDE) * AW'(irq_idx);

    always_comb begin
        pc_mux_sel = 1'b0;
        jmp_loc    = jmp_address_pm;
        push       = 1'b0;
        pop        = 1'b0;
        wdata      = '{flags: flag_ex, addr: current_address, level: level};
        priority case (1'b1)
            // The squashed op re-executes after RETI, so save its own PC.
            accept: begin
                pc_mux_sel = 1'b1;
                jmp_loc    = vec_addr;
                push       = 1'b1;
            end
            is_call: begin
                if (!full) begin
                    pc_mux_sel = 1'b1;
                    push       = 1'b1;
                    wdata.addr = current_address + 1'b1;
                end
            end
            is_ret: begin
                if (!empty) begin
                    pc_mux_sel = 1'b1;
                    jmp_loc    = top.addr;
                    pop        = 1'b1;
                end
            end
            default: pc_mux_sel = br_taken;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            level            <= LEVEL_NONE;
            irq_ack          <= '0;
            flag_restore     <= '0;
            flag_restore_vld <= 1'b0;
            stack_ovf        <= 1'b0;
            stack_unf        <= 1'b0;
        end else begin
            irq_ack          <= accept ? (NIRQ'(1) << irq_idx) : '0;
            flag_restore_vld <= pop;
            if (pop) begin
                flag_restore <= top.flags;
            end
            if (is_call && !accept && full) begin
                stack_ovf <= 1'b1;
            end
            if (is_ret && !accept && empty) begin
                stack_unf <= 1'b1;
            end
            if (accept) begin
                level <= irq_idx;
                state <= ISR;
            end else if (pop && is_reti) begin
                level <= top.level;
                if (top.level == LEVEL_NONE) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_control_stack.sv
// Self-checking bench for branch_control_stack: directed scenarios
// followed by random stimulus against a queue-based reference model.
module tb_branch_control_stack;

    localparam int DEPTH = 8;
    localparam int NIRQ  = 4;

    localparam logic [5:0] JMP  = 6'b011000;
    localparam logic [5:0] CALL = 6'b011001;
    localparam logic [5:0] RET  = 6'b010000;
    localparam logic [5:0] RETI = 6'b010001;
    localparam logic [5:0] JV   = 6'b011100;
    localparam logic [5:0] JNV  = 6'b011101;
    localparam logic [5:0] JZ   = 6'b011110;
    localparam logic [5:0] JNZ  = 6'b011111;
    localparam logic [5:0] NOP  = 6'b000000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  op = NOP;
    logic [15:0] current_address = '0;
    logic [15:0] jmp_address_pm = '0;
    logic [1:0]  flag_ex = '0;
    logic [3:0]  irq = '0;
    logic        irq_en = 1'b0;
    logic        pc_mux_sel;
    logic [15:0] jmp_loc;
    logic [1:0]  flag_restore;
    logic        flag_restore_vld;
    logic [3:0]  irq_ack;
    logic [3:0]  stack_depth;
    logic        stack_ovf;
    logic        stack_unf;

    branch_control_stack dut (
        .clk              (clk),
        .reset            (reset),
        .op               (op),
        .current_address  (current_address),
        .jmp_address_pm   (jmp_address_pm),
        .flag_ex          (flag_ex),
        .irq              (irq),
        .irq_en           (irq_en),
        .pc_mux_sel       (pc_mux_sel),
        .jmp_loc          (jmp_loc),
        .flag_restore     (flag_restore),
        .flag_restore_vld (flag_restore_vld),
        .irq_ack          (irq_ack),
        .stack_depth      (stack_depth),
        .stack_ovf        (stack_ovf),
        .stack_unf        (stack_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int flags;
        int addr;
        int lev;
    } ent_t;

    // Reference model: level -1 means no active interrupt.
    ent_t stk[$];
    bit   m_isr;
    int   m_lev;
    bit   m_ovf;
    bit   m_unf;

    int   errors = 0;
    int   checks = 0;
    logic o_sel;
    logic [15:0] o_loc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        m_isr = 1'b0;
        m_lev = -1;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic step(input logic [5:0] o, input logic [15:0] pc,
                        input logic [15:0] tgt, input logic [1:0] f,
                        input logic [3:0] rq, input logic en,
                        input logic rst);
        int   n;
        int   idx;
        bit   elig;
        bit   acc;
        bit   e_sel;
        int   e_loc;
        int   kind;
        int   e_ack;
        bit   e_vld;
        int   e_fr;
        ent_t e;
        @(negedge clk);
        op = o;
        current_address = pc;
        jmp_address_pm = tgt;
        flag_ex = f;
        irq = rq;
        irq_en = en;
        reset = rst;
        #1;
        o_sel = pc_mux_sel;
        o_loc = jmp_loc;
        n = stk.size();
        idx = -1;
        for (int i = NIRQ - 1; i >= 0; i--) if (rq[i]) idx = i;
        elig = !m_isr;
`ifdef BCS_NESTED_IRQ_EN
        if (m_isr && idx >= 0 && idx < m_lev) elig = 1'b1;
`endif
        acc = en && idx >= 0 && n < DEPTH && elig;
        e_sel = 1'b0;
        e_loc = tgt;
        kind = 0;
        if (acc) begin
            e_sel = 1'b1;
            e_loc = 'hF000 + idx * 4;
            kind = 1;
        end else if (o == CALL) begin
            if (n < DEPTH) begin
                e_sel = 1'b1;
                kind = 2;
            end else kind = 4;
        end else if (o == RET || o == RETI) begin
            if (n > 0) begin
                e_sel = 1'b1;
                e_loc = stk[$].addr;
                kind = 3;
            end else kind = 5;
        end else begin
            case (o)
                JMP: e_sel = 1'b1;
                JV:  e_sel = f[0];
                JNV: e_sel = !f[0];
                JZ:  e_sel = f[1];
                JNZ: e_sel = !f[1];
                default: e_sel = 1'b0;
            endcase
        end
        if (rst) begin
            chk("pc_mux_sel", 32'(o_sel), 32'(e_sel));
            if (e_sel) chk("jmp_loc", 32'(o_loc), 32'(e_loc));
        end
        @(posedge clk);
        #1;
        e_ack = 0;
        e_vld = 1'b0;
        e_fr = 0;
        if (!rst) begin
            model_reset();
        end else begin
            case (kind)
                1: begin
                    stk.push_back('{flags: int'(f), addr: int'(pc), lev: m_lev});
                    e_ack = 1 << idx;
                    m_lev = idx;
                    m_isr = 1'b1;
                end
                2: stk.push_back('{flags: int'(f),
                                   addr: (int'(pc) + 1) % 65536,
                                   lev: m_lev});
                3: begin
                    e = stk.pop_back();
                    e_vld = 1'b1;
                    e_fr = e.flags;
                    if (o == RETI) begin
                        m_lev = e.lev;
                        if (e.lev < 0) m_isr = 1'b0;
                    end
                end
                4: m_ovf = 1'b1;
                5: m_unf = 1'b1;
                default: ;
            endcase
        end
        chk("irq_ack", 32'(irq_ack), 32'(e_ack));
        chk("flag_restore_vld", 32'(flag_restore_vld), 32'(e_vld));
        if (e_vld) chk("flag_restore", 32'(flag_restore), 32'(e_fr));
        if (!rst) chk("flag_restore_rst", 32'(flag_restore), 32'd0);
        chk("stack_depth", 32'(stack_depth), 32'(stk.size()));
        chk("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
        chk("stack_unf", 32'(stack_unf), 32'(m_unf));
        chk("state", 32'(dut.state), 32'(m_isr));
    endtask

    initial begin
        model_reset();

        // Reset
        step(NOP, 16'h0, 16'h0, 2'b00, 4'h0, 1'b0, 1'b0);
        step(NOP, 16'h0, 16'h0, 2'b00, 4'h0, 1'b0, 1'b0);

        // 1: conditional jump on Z
        step(JZ, 16'h0010, 16'h0040, 2'b10, 4'h0, 1'b0, 1'b1);
        chk("t1_sel", 32'(o_sel), 32'd1);
        chk("t1_loc", 32'(o_loc), 32'h0040);
        step(JZ, 16'h0010, 16'h0040, 2'b00, 4'h0, 1'b0, 1'b1);
        chk("t1_nsel", 32'(o_sel), 32'd0);

        // 2: CALL then RET
        step(CALL, 16'h0100, 16'h0200, 2'b01, 4'h0, 1'b0, 1'b1);
        chk("t2_depth1", 32'(stack_depth), 32'd1);
        step(RET, 16'h0200, 16'h0000, 2'b00, 4'h0, 1'b0, 1'b1);
        chk("t2_loc", 32'(o_loc), 32'h0101);
        chk("t2_vld", 32'(flag_restore_vld), 32'd1);
        chk("t2_depth0", 32'(stack_depth), 32'd0);
        step(NOP, 16'h0101, 16'h0000, 2'b00, 4'h0, 1'b0, 1'b1);

        // 3: interrupt accept and RETI
        step(NOP, 16'h0300, 16'h0000, 2'b10, 4'b0110, 1'b1, 1'b1);
        chk("t3_loc", 32'(o_loc), 32'hF004);
        chk("t3_ack", 32'(irq_ack), 32'b0010);
        step(NOP, 16'hF004, 16'h0000, 2'b00, 4'h0, 1'b1, 1'b1);
        step(RETI, 16'hF008, 16'h0000, 2'b00, 4'h0, 1'b1, 1'b1);
        chk("t3_ret", 32'(o_loc), 32'h0300);

        // 4: overflow and underflow
        for (int i = 0; i < DEPTH; i++)
            step(CALL, 16'(16'h0400 + i), 16'h0500, 2'b01, 4'h0, 1'b0, 1'b1);
        step(CALL, 16'h0408, 16'h0500, 2'b01, 4'h0, 1'b0, 1'b1);
        chk("t4_nsel", 32'(o_sel), 32'd0);
        chk("t4_ovf", 32'(stack_ovf), 32'd1);
        for (int i = 0; i < DEPTH; i++)
            step(RET, 16'h0500, 16'h0000, 2'b00, 4'h0, 1'b0, 1'b1);
        step(RET, 16'h0500, 16'h0000, 2'b00, 4'h0, 1'b0, 1'b1);
        chk("t4_unf", 32'(stack_unf), 32'd1);
        step(NOP, 16'h0, 16'h0, 2'b00, 4'h0, 1'b0, 1'b0);

        // 5: higher-priority irq while in ISR at level 2
        step(NOP, 16'h0600, 16'h0000, 2'b00, 4'b0100, 1'b1, 1'b1);
        chk("t5_vec2", 32'(o_loc), 32'hF008);
`ifdef BCS_NESTED_IRQ_EN
        step(NOP, 16'hF008, 16'h0000, 2'b00, 4'b0001, 1'b1, 1'b1);
        chk("t5_pre_loc", 32'(o_loc), 32'hF000);
        chk("t5_pre_ack", 32'(irq_ack), 32'b0001);
        step(RETI, 16'hF000, 16'h0000, 2'b00, 4'h0, 1'b1, 1'b1);
        chk("t5_back", 32'(o_loc), 32'hF008);
        chk("t5_lvl", 32'(dut.level), 32'd2);
        step(RETI, 16'hF00C, 16'h0000, 2'b00, 4'h0, 1'b1, 1'b1);
        chk("t5_home", 32'(o_loc), 32'h0600);
`else
        step(NOP, 16'hF008, 16'h0000, 2'b00, 4'b0001, 1'b1, 1'b1);
        chk("t5_nosel", 32'(o_sel), 32'd0);
        chk("t5_noack", 32'(irq_ack), 32'd0);
        step(RETI, 16'hF00C, 16'h0000, 2'b00, 4'b0001, 1'b1, 1'b1);
        chk("t5_home", 32'(o_loc), 32'h0600);
        step(NOP, 16'h0600, 16'h0000, 2'b00, 4'b0001, 1'b1, 1'b1);
        chk("t5_late_loc", 32'(o_loc), 32'hF000);
        chk("t5_late_ack", 32'(irq_ack), 32'b0001);
        step(RETI, 16'hF000, 16'h0000, 2'b00, 4'h0, 1'b1, 1'b1);
`endif

        // 6: reset mid-ISR with three entries
        step(RET, 16'h0, 16'h0, 2'b00, 4'h0, 1'b0, 1'b1);
        step(NOP, 16'h0700, 16'h0, 2'b11, 4'b1000, 1'b1, 1'b1);
        step(CALL, 16'hF00C, 16'h0800, 2'b01, 4'h0, 1'b1, 1'b1);
        step(CALL, 16'h0800, 16'h0900, 2'b10, 4'h0, 1'b1, 1'b1);
        chk("t6_depth3", 32'(stack_depth), 32'd3);
        step(NOP, 16'h0, 16'h0, 2'b00, 4'h0, 1'b0, 1'b0);
        chk("t6_depth0", 32'(stack_depth), 32'd0);
        chk("t6_unf", 32'(stack_unf), 32'd0);
        chk("t6_idle", 32'(dut.state), 32'd0);

        // Random phase
        for (int c = 0; c < 600; c++) begin
            logic [5:0]  ro;
            logic [3:0]  rq;
            int          pick;
            pick = int'($urandom_range(0, 11));
            case (pick)
                0: ro = JMP;
                1, 2: ro = CALL;
                3: ro = RET;
                4, 5: ro = RETI;
                6: ro = JV;
                7: ro = JNV;
                8: ro = JZ;
                9: ro = JNZ;
                10: ro = NOP;
                default: ro = 6'($urandom);
            endcase
            rq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step(ro, 16'($urandom), 16'($urandom), 2'($urandom), rq,
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 79) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
